// File: rtl/exec_seq_ctrl_pkg.sv
// Shared definitions for the sequencer, the execute unit and the bench:
// opcode constants, FSM state encoding and opcode classification.
package exec_seq_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned WAIT_W  = 2;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    // Post-EXEC routing class of an instruction
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_UNKNOWN = 3'd4
    } op_class_e;

    function automatic op_class_e classify(input logic [OPC_W-1:0] opc);
        op_class_e cls;
        cls = CLS_UNKNOWN;
        case (opc)
            OPC_R, OPC_I, OPC_JAL, OPC_JALR: cls = CLS_ALU;
            OPC_LOAD:                        cls = CLS_LOAD;
            OPC_STORE:                       cls = CLS_STORE;
            OPC_BRANCH:                      cls = CLS_BRANCH;
            default:                         cls = CLS_UNKNOWN;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/exec_seq_ctrl_handshake.sv
// Request-hold / ack-capture helper shared by the instruction and data ports.
// The request is a registered level; an ack only counts while it is raised.
module exec_seq_handshake (
    input  logic clk,
    input  logic rst,
    input  logic req_next,
    input  logic ack,
    output logic req,
    output logic done_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req <= 1'b0;
        end else begin
            req <= req_next;
        end
    end

    // Stray acks with no request outstanding are dropped here
    assign done_c = req & ack;

endmodule

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a simple RV32-style core.
// Build option: EXEC_SEQ_MISALIGN_TRAP_EN adds a TRAP state for misaligned next-PC.
module exec_seq_ctrl
    import exec_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned EXEC_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [31:0] ir,
    output logic [31:0] pc,
    input  logic [31:0] ex_next_pc,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    localparam logic [WAIT_W-1:0] EXEC_LAST = WAIT_W'(EXEC_WAIT);
    localparam logic [XLEN-1:0]   ALIGN_MASK = ~XLEN'(3);

    state_e            state_q;
    state_e            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   ir_q;
    logic [XLEN-1:0]   retired_q;
    logic [XLEN-1:0]   npc_q;
    logic [XLEN-1:0]   tgt_c;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              dmem_we_q;
    logic              dmem_we_d;
    logic              rf_we_q;
    logic              rf_we_d;
    logic              imem_req_d;
    logic              dmem_req_d;
    logic              imem_done_c;
    logic              dmem_done_c;
    logic              exec_last_c;
    logic              retire_c;
    logic              commit_c;
    op_class_e         cls_c;

    assign cls_c = classify(ir_q[OPC_W-1:0]);

    exec_seq_handshake u_imem_hs (
        .clk      (clk),
        .rst      (rst),
        .req_next (imem_req_d),
        .ack      (imem_ack),
        .req      (imem_req),
        .done_c   (imem_done_c)
    );

    exec_seq_handshake u_dmem_hs (
        .clk      (clk),
        .rst      (rst),
        .req_next (dmem_req_d),
        .ack      (dmem_ack),
        .req      (dmem_req),
        .done_c   (dmem_done_c)
    );

    // Branch and unknown opcodes retire straight out of EXEC, so they use the live value
    always_comb begin
        tgt_c = npc_q;
        if (cls_c == CLS_UNKNOWN) begin
            tgt_c = pc_q + XLEN'(4);
        end else if (state_q == ST_EXEC) begin
            tgt_c = ex_next_pc;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        exec_last_c = 1'b0;
        retire_c    = 1'b0;
        commit_c    = 1'b0;
        pc_d        = tgt_c & ALIGN_MASK;

        case (state_q)
            ST_FETCH: begin
                if (imem_done_c) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (wait_q == EXEC_LAST) begin
                    exec_last_c = 1'b1;
                    case (cls_c)
                        CLS_ALU:             state_d = ST_WB;
                        CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                        default:             retire_c = 1'b1;
                    endcase
                end else begin
                    wait_d = WAIT_W'(wait_q + WAIT_W'(1));
                end
            end
            ST_MEM: begin
                if (dmem_done_c) begin
                    if (cls_c == CLS_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        retire_c = 1'b1;
                    end
                end
            end
            ST_WB: begin
                retire_c = 1'b1;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (retire_c) begin
`ifdef EXEC_SEQ_MISALIGN_TRAP_EN
            if (tgt_c[1:0] != 2'b00) begin
                state_d = ST_TRAP;
            end else begin
                state_d  = ST_FETCH;
                commit_c = 1'b1;
            end
`else
            state_d  = ST_FETCH;
            commit_c = 1'b1;
`endif
        end

        imem_req_d = (state_d == ST_FETCH);
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) && (cls_c == CLS_STORE);
        rf_we_d    = (state_d == ST_WB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
            npc_q     <= '0;
            wait_q    <= '0;
            dmem_we_q <= 1'b0;
            rf_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            dmem_we_q <= dmem_we_d;
            rf_we_q   <= rf_we_d;
            if ((state_q == ST_FETCH) && imem_done_c) begin
                ir_q <= imem_rdata;
            end
            if (exec_last_c) begin
                npc_q <= ex_next_pc;
            end
            if (commit_c) begin
                pc_q      <= pc_d;
                retired_q <= retired_q + XLEN'(1);
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign retired   = retired_q;
    assign dmem_we   = dmem_we_q;
    assign rf_we     = rf_we_q;
    assign state     = state_q;

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed bench for exec_seq_ctrl: a table of single-instruction vectors
// followed by hand-written reset, counter-wrap and misaligned-target sequences.
module tb_exec_seq_ctrl;
    import exec_seq_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int NVEC = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] ex_next_pc = '0;
    logic        rf_we;
    logic [2:0]  state;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;

    exec_seq_ctrl #(
        .RESET_PC  (RST_PC),
        .EXEC_WAIT (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .ir         (ir),
        .pc         (pc),
        .ex_next_pc (ex_next_pc),
        .rf_we      (rf_we),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] npc;
        int          iwait;
        int          dwait;
        bit          stray;
        int          exp_cyc;
        logic [31:0] exp_pc;
        int          exp_rfw;
        int          exp_dreq;
        int          exp_dwe;
    } vec_t;

    typedef struct {
        int cyc;
        int rfw;
        int dreq;
        int dwe;
        int rule_err;
        bit timeout;
    } res_t;

    vec_t vecs[NVEC];

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    // Plays fetch and data responders for one instruction; samples on negedge
    task automatic run_instr(input vec_t v, output res_t r);
        logic [31:0] r0;
        int  icnt;
        int  dcnt;
        bit  done;
        r = '{default: 0};
        r0 = retired;
        icnt = 0;
        dcnt = 0;
        done = 1'b0;
        ex_next_pc = v.npc;
        for (int g = 0; g < 20 && !imem_req; g++) begin
            imem_ack = v.stray;
            dmem_ack = v.stray;
            @(negedge clk);
        end
        if (!imem_req) begin
            r.timeout = 1'b1;
            return;
        end
        for (int g = 0; g < 100 && !done; g++) begin
            if (rf_we) r.rfw++;
            if (dmem_req) r.dreq++;
            if (dmem_we) r.dwe++;
            if (imem_req && dmem_req) r.rule_err++;
            if (rf_we && (state != 3'(ST_WB))) r.rule_err++;
            if (imem_req && (imem_addr != pc)) r.rule_err++;
            if (imem_req) begin
                imem_ack   = (icnt >= v.iwait);
                imem_rdata = v.word;
                icnt++;
            end else begin
                imem_ack   = v.stray;
                imem_rdata = 32'hFFFF_FFFF;
            end
            if (dmem_req) begin
                dmem_ack = (dcnt >= v.dwait);
                dcnt++;
            end else begin
                dmem_ack = v.stray;
            end
            r.cyc++;
            @(negedge clk);
            if ((retired != r0) || (state == 3'(ST_TRAP))) done = 1'b1;
        end
        if (!done) r.timeout = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic check_vec(input vec_t v, input res_t r, input int idx, input logic [31:0] r0);
        check("timeout", idx, 32'(r.timeout), 32'd0);
        check("latency", idx, 32'(r.cyc), 32'(v.exp_cyc));
        check("pc", idx, pc, v.exp_pc);
        check("ir", idx, ir, v.word);
        check("rf_we_pulses", idx, 32'(r.rfw), 32'(v.exp_rfw));
        check("dmem_req_cycles", idx, 32'(r.dreq), 32'(v.exp_dreq));
        check("dmem_we_cycles", idx, 32'(r.dwe), 32'(v.exp_dwe));
        check("rule_violations", idx, 32'(r.rule_err), 32'd0);
        check("retired", idx, retired, r0 + 32'd1);
    endtask

    task automatic check_reset_state(input int idx);
        check("rst_state", idx, 32'(state), 32'(ST_FETCH));
        check("rst_pc", idx, pc, RST_PC);
        check("rst_ir", idx, ir, 32'd0);
        check("rst_retired", idx, retired, 32'd0);
        check("rst_imem_req", idx, 32'(imem_req), 32'd0);
        check("rst_dmem_req", idx, 32'(dmem_req), 32'd0);
        check("rst_dmem_we", idx, 32'(dmem_we), 32'd0);
        check("rst_rf_we", idx, 32'(rf_we), 32'd0);
    endtask

    initial begin
        vec_t  v;
        res_t  r;
        logic [31:0] r0;
        logic [31:0] pc_before;
        bit    got;

        //                word          npc           iw dw st cyc exp_pc        rf dq dwe
        vecs[0]  = '{32'h0050_0093, 32'h0000_0004, 1, 0, 0, 5, 32'h0000_0004, 1, 0, 0}; // ADDI
        vecs[1]  = '{32'h0000_A103, 32'h0000_0008, 0, 3, 0, 8, 32'h0000_0008, 1, 4, 0}; // LW, ack after 3 waits
        vecs[2]  = '{32'h0000_0063, 32'h0000_0020, 0, 0, 0, 3, 32'h0000_0020, 0, 0, 0}; // BEQ taken
        vecs[3]  = '{32'h0020_A023, 32'h0000_0024, 0, 0, 1, 4, 32'h0000_0024, 0, 1, 1}; // SW
        vecs[4]  = '{32'h0080_006F, 32'h0000_0040, 2, 0, 1, 6, 32'h0000_0040, 1, 0, 0}; // JAL
        vecs[5]  = '{32'h0020_81B3, 32'h0000_0044, 0, 0, 0, 4, 32'h0000_0044, 1, 0, 0}; // ADD
        vecs[6]  = '{32'h0000_007F, 32'hDEAD_0000, 0, 0, 1, 3, 32'h0000_0048, 0, 0, 0}; // unknown -> pc+4
        vecs[7]  = '{32'h0000_A103, 32'h0000_004C, 0, 0, 1, 5, 32'h0000_004C, 1, 1, 0}; // LW zero-wait
        vecs[8]  = '{32'h0000_8067, 32'h0000_0080, 0, 0, 0, 4, 32'h0000_0080, 1, 0, 0}; // JALR
        vecs[9]  = '{32'h0000_0063, 32'h0000_0084, 0, 0, 0, 3, 32'h0000_0084, 0, 0, 0}; // BEQ not taken
        vecs[10] = '{32'h0020_A023, 32'h0000_0088, 0, 2, 0, 6, 32'h0000_0088, 0, 3, 3}; // SW, 2 waits

        // Reset state and first request after release
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state(0);
        rst = 1'b0;
        check("imem_req_before_edge", 0, 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        check("imem_req_first_edge", 0, 32'(imem_req), 32'd1);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            r0 = retired;
            run_instr(vecs[i], r);
            check_vec(vecs[i], r, i, r0);
        end

        // Counter wrap: preload FFFF_FFFF, then one STORE retires
        @(negedge clk);
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        v = '{32'h0020_A023, 32'h0000_008C, 0, 0, 0, 4, 32'h0000_008C, 0, 1, 1};
        run_instr(v, r);
        check("wrap_timeout", 0, 32'(r.timeout), 32'd0);
        check("wrap_retired", 0, retired, 32'd0);
        check("wrap_pc", 0, pc, 32'h0000_008C);

        // JALR to a misaligned target
        r0 = retired;
        pc_before = pc;
        v = '{32'h0000_8067, 32'h0000_0102, 0, 0, 0, 4, 32'h0000_0100, 1, 0, 0};
        run_instr(v, r);
        check("misalign_timeout", 0, 32'(r.timeout), 32'd0);
`ifdef EXEC_SEQ_MISALIGN_TRAP_EN
        repeat (3) @(negedge clk);
        check("trap_state", 0, 32'(state), 32'(ST_TRAP));
        check("trap_retired", 0, retired, r0);
        check("trap_pc", 0, pc, pc_before);
        check("trap_imem_req", 0, 32'(imem_req), 32'd0);
        check("trap_dmem_req", 0, 32'(dmem_req), 32'd0);
        check("trap_rf_we", 0, 32'(rf_we), 32'd0);
`else
        check("misalign_pc", 0, pc, 32'h0000_0100);
        check("misalign_retired", 0, retired, r0 + 32'd1);
        check("misalign_rf_we", 0, 32'(r.rfw), 32'd1);
`endif

        // Reset asserted mid data handshake of a STORE
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        v = '{32'h0050_0093, RST_PC + 32'd4, 0, 0, 0, 4, RST_PC + 32'd4, 1, 0, 0};
        r0 = retired;
        run_instr(v, r);
        check_vec(v, r, 20, r0);
        ex_next_pc = 32'h0000_0200;
        got = 1'b0;
        for (int g = 0; g < 10 && !got; g++) begin
            if (imem_req) got = 1'b1;
            else @(negedge clk);
        end
        imem_rdata = 32'h0020_A023;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        got = 1'b0;
        for (int g = 0; g < 10 && !got; g++) begin
            if (dmem_req) got = 1'b1;
            else @(negedge clk);
        end
        check("sw_dmem_req_seen", 0, 32'(got), 32'd1);
        check("sw_dmem_we", 0, 32'(dmem_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_state(1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("imem_req_after_midrst", 0, 32'(imem_req), 32'd1);
        check("dmem_req_after_midrst", 0, 32'(dmem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_seq_ctrl.md
EXEC_SEQ_CTRL -- requirements
Module: exec_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter EXEC_WAIT, default 0, extra idle cycles inserted in EXEC (0-3) for ALU settling.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req / imem_addr  output  1 / 32  instruction fetch request and word address (= pc).
REQ-006 SHALL have port imem_ack / imem_rdata  input  1 / 32  fetch completion and instruction word.
REQ-007 SHALL have port dmem_req / dmem_we  output  1 / 1  data access request and write strobe (1 = STORE).
REQ-008 SHALL have port dmem_ack  input  1  data access completion.
REQ-009 SHALL have port ir  output  32  latched instruction register; ir[6:0] drives the execute unit's opcode.
REQ-010 SHALL have port pc  output  32  current PC, driven to the execute unit.
REQ-011 SHALL have port ex_next_pc  input  32  next-PC computed by the execute unit.
REQ-012 SHALL have port rf_we  output  1  register-file write enable, one-cycle pulse.
REQ-013 SHALL have port state  output  3  current FSM state encoding.
REQ-014 SHALL have port retired  output  32  count of completed instructions.

Function
REQ-015 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB; no other reachable states except TRAP when the configuration feature is compiled in.
REQ-016 FETCH: imem_req SHALL be 1 with imem_addr = pc until imem_ack is sampled 1; then ir <= imem_rdata, imem_req drops the next cycle, and the FSM goes to DECODE.
REQ-017 imem_ack or dmem_ack asserted with no request outstanding SHALL be ignored.
REQ-018 DECODE SHALL last exactly 1 cycle, then go to EXEC.
REQ-019 EXEC SHALL last 1+EXEC_WAIT cycles; ex_next_pc is sampled on its last cycle.
REQ-020 After EXEC: LOAD (0000011) and STORE (0100011) go to MEM; R (0110011), I (0010011), JAL (1101111) and JALR (1100111) go to WB; BRANCH (1100011) and unknown opcodes retire directly.
REQ-021 MEM SHALL hold dmem_req=1, with dmem_we=1 for STORE only, until dmem_ack=1; then LOAD goes to WB and STORE retires.
REQ-022 WB SHALL assert rf_we for exactly 1 cycle, then retire.
REQ-023 Retire SHALL do pc <= sampled ex_next_pc, retired <= retired+1 (32-bit, wraps FFFF_FFFF->0), and go to FETCH, all in one edge.
REQ-024 Unknown opcode SHALL retire with pc <= pc+4 regardless of ex_next_pc, and produce no rf_we and no dmem_req.
REQ-025 Minimum latency with zero-wait ack and EXEC_WAIT=0 SHALL be: R/I/JAL/JALR 4 cycles, BRANCH 3, LOAD 5, STORE 4.
REQ-026 dmem_req and imem_req SHALL never be 1 in the same cycle; rf_we SHALL only be 1 in WB.

Reset
REQ-027 rst=1 SHALL immediately force state=FETCH, pc=RESET_PC, ir=0, retired=0, and imem_req=dmem_req=dmem_we=rf_we=0, including mid-handshake.
REQ-028 After rst deasserts, imem_req SHALL rise on the first clock edge.

Configuration
REQ-029 Macro EXEC_SEQ_MISALIGN_TRAP_EN: when defined, a retire with sampled ex_next_pc[1:0]!=0 SHALL enter TRAP instead (pc frozen, all requests 0, retired not incremented, state held until rst).
REQ-030 Without EXEC_SEQ_MISALIGN_TRAP_EN, ex_next_pc SHALL be loaded with bits [1:0] forced to 0, and TRAP SHALL not exist.

Structure
REQ-031 A shared package SHALL hold the opcode constants (R, I, LOAD, STORE, BRANCH, JAL, JALR) and the FSM state encoding, both common with the execute unit and bench.
REQ-032 The block SHALL be one module, except for an optional sub-module exec_seq_handshake (request-hold/ack-capture) instantiated for imem and dmem.

Verification
REQ-033 ADDI word 0x00500093, imem_ack 1 cycle after req, ex_next_pc=0x4 -> FETCH,DECODE,EXEC,WB; rf_we one pulse; pc=0x4; retired=1.
REQ-034 LW, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0; rf_we pulses after ack; retired=1.
REQ-035 BEQ taken with ex_next_pc=0x20 at pc=0x8 -> no rf_we, no dmem_req; pc=0x20 after 3 cycles.
REQ-036 rst pulsed while dmem_req=1 for SW -> dmem_req=0 immediately; pc=RESET_PC; retired=0; imem_req=1 on the next edge.
REQ-037 JALR with ex_next_pc=0x102 -> with the macro defined: TRAP, retired unchanged; without it: pc=0x100.
REQ-038 retired preloaded to 0xFFFF_FFFF, then one STORE retires -> retired=0.
